// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching instruction-fetch front end with DEPTH-entry word FIFO
module fetch_queue #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RstAddr   = 32'h80000000,
  parameter logic [WIDTH-1:0] XAddr     = 32'h80000008,
  parameter logic [WIDTH-1:0] IllOpAddr = 32'h80000004
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             IRQ,
  input  logic             illop,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  output logic             xp_valid,
  output logic [WIDTH-1:0] xp_pc
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [AW:0]      FULL      = (AW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] WORD_MASK = ~(WIDTH'(3));

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_addr;
  logic             live;
  logic [2:0]       stale_cnt;
  logic             sup;

  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [WIDTH-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic             head_valid;
  logic [WIDTH-1:0] head_pc;
  logic             irq_take;
  logic             flush;
  logic             issue;
  logic             ack_stale;
  logic             ack_live;
  logic             abandon;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] flush_pc;
  logic [WIDTH-1:0] pc_inc;
  logic [2:0]       stale_next;

  assign head_valid = (count != '0);
  assign head_pc    = fifo_pc[rd_ptr];
  assign irq_take   = IRQ && head_valid && !head_pc[WIDTH-1] && !illop && !redirect_valid;
  assign flush      = illop || redirect_valid || irq_take;

  // Abandoned requests are still answered by memory; stale_cnt counts acks to discard.
  assign issue      = RESET && !live && (count < FULL) && (stale_cnt != 3'd7) && !flush;
  assign ack_stale  = imem_ack && (stale_cnt != '0);
  assign ack_live   = imem_ack && (stale_cnt == '0) && live;
  assign abandon    = live && !ack_live && (flush || !RESET);
  assign stale_next = stale_cnt - 3'(ack_stale) + 3'(abandon);
  assign push       = ack_live && !flush;
  assign pop        = head_valid && inst_ready && !flush;

  // Supervisor bit is held across increment; user redirects cannot set it.
  assign pc_inc = {fetch_pc[WIDTH-1], fetch_pc[WIDTH-2:0] + (WIDTH-1)'(4)};

  always_comb begin
    flush_pc = XAddr;
    if (illop)
      flush_pc = IllOpAddr;
    else if (redirect_valid)
      flush_pc = {redirect_pc[WIDTH-1] & sup, redirect_pc[WIDTH-2:0]} & WORD_MASK;
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      fetch_pc  <= RstAddr;
      req_addr  <= '0;
      live      <= 1'b0;
      stale_cnt <= stale_next;
      sup       <= 1'b1;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      stale_cnt <= stale_next;
      if (flush)
        fetch_pc <= flush_pc;
      else if (issue)
        fetch_pc <= pc_inc;

      if (issue) begin
        live     <= 1'b1;
        req_addr <= fetch_pc & WORD_MASK;
      end else if (ack_live || flush) begin
        live <= 1'b0;
      end

      if (pop)
        sup <= head_pc[WIDTH-1];

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET && push) begin
      fifo_data[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]   <= req_addr;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = issue ? (fetch_pc & WORD_MASK) : '0;
  assign inst_valid = head_valid;
  assign inst_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = head_valid ? head_pc : '0;
  assign xp_valid   = irq_take;
  assign xp_pc      = irq_take ? head_pc + WIDTH'(4) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RST = 32'h80000000;
  localparam logic [31:0] XA  = 32'h80000008;
  localparam logic [31:0] ILL = 32'h80000004;

  logic        clk;
  logic        RESET;
  logic        IRQ;
  logic        illop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        xp_valid;
  logic [31:0] xp_pc;

  fetch_queue #(.WIDTH(W), .DEPTH(D), .RstAddr(RST), .XAddr(XA), .IllOpAddr(ILL)) dut (
    .clk(clk), .RESET(RESET), .IRQ(IRQ), .illop(illop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .xp_valid(xp_valid), .xp_pc(xp_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [31:0] pc; } entry_t;
  typedef struct { logic wanted; logic [31:0] addr; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  entry_t  m_fifo[$];
  flight_t m_fl[$];
  logic [31:0] m_pc;
  logic        m_sup;
  bit          model_ok;

  mreq_t mem_q[$];
  int    lat_lo, lat_hi;
  logic [31:0] salt;

  logic        drv_reset, drv_irq, drv_illop, drv_redir, drv_ready;
  logic [31:0] drv_rpc;

  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];
  logic [31:0] xp_log[$];

  int errors, checks, cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_at(string name, logic [31:0] q[$], int idx, logic [31:0] exp);
    if (idx < q.size()) chk(name, q[idx], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d entry %0d missing expected=%h", name, cyc, idx, exp);
    end
  endtask

  task automatic step();
    logic        ack, hv, irq_t, fl, ereq, has_w;
    entry_t      head;
    flight_t     f;
    logic [31:0] npc;
    @(negedge clk);
    cyc++;
    RESET          = drv_reset;
    IRQ            = drv_irq;
    illop          = drv_illop;
    redirect_valid = drv_redir;
    redirect_pc    = drv_rpc;
    inst_ready     = drv_ready;
    ack            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_ack       = ack;
    imem_data      = ack ? (mem_q[0].addr ^ salt) : $urandom;
    #1;
    hv        = m_fifo.size() > 0;
    head.data = '0;
    head.pc   = '0;
    if (hv) head = m_fifo[0];
    irq_t = drv_irq && hv && !head.pc[31] && !drv_illop && !drv_redir;
    fl    = drv_illop || drv_redir || irq_t;
    has_w = 1'b0;
    foreach (m_fl[i]) if (m_fl[i].wanted) has_w = 1'b1;
    ereq  = drv_reset && !has_w && (m_fifo.size() < D) && !fl;
    if (model_ok) begin
      chk("imem_req", 32'(imem_req), 32'(ereq));
      chk("imem_addr", imem_addr, ereq ? m_pc : 32'h0);
      chk("inst_valid", 32'(inst_valid), 32'(hv));
      chk("inst_data", inst_data, head.data);
      chk("inst_pc", inst_pc, head.pc);
      chk("xp_valid", 32'(xp_valid), 32'(irq_t));
      chk("xp_pc", xp_pc, irq_t ? head.pc + 32'd4 : 32'h0);
    end
    if (imem_req) req_log.push_back(imem_addr);
    if (inst_valid && inst_ready && !illop && !redirect_valid && !xp_valid) begin
      pop_pc_log.push_back(inst_pc);
      pop_data_log.push_back(inst_data);
    end
    if (xp_valid) xp_log.push_back(xp_pc);
    if (ack) void'(mem_q.pop_front());
    if (imem_req)
      mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
    if (!drv_reset) begin
      if (ack && m_fl.size() > 0) void'(m_fl.pop_front());
      foreach (m_fl[i]) m_fl[i].wanted = 1'b0;
      m_fifo.delete();
      m_pc     = RST;
      m_sup    = 1'b1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (hv && drv_ready && !fl) begin
        m_sup = head.pc[31];
        void'(m_fifo.pop_front());
      end
      if (ack && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (f.wanted && !fl) m_fifo.push_back('{data: imem_data, pc: f.addr});
      end
      if (fl) begin
        if (drv_illop) npc = ILL;
        else if (drv_redir) npc = {drv_rpc[31] & m_sup, drv_rpc[30:2], 2'b00};
        else npc = XA;
        m_fifo.delete();
        foreach (m_fl[i]) m_fl[i].wanted = 1'b0;
        m_pc = npc;
      end
      if (ereq) begin
        m_fl.push_back('{wanted: 1'b1, addr: m_pc});
        m_pc = {m_pc[31], m_pc[30:0] + 31'd4};
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_data_log.delete();
    xp_log.delete();
  endtask

  task automatic do_reset();
    drv_reset = 1'b0;
    run(3);
    drv_reset = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_redir(logic [31:0] pc);
    drv_redir = 1'b1;
    drv_rpc   = pc;
    step();
    drv_redir = 1'b0;
  endtask

  task automatic wait_pop(string name, logic [31:0] pc, int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      foreach (pop_pc_log[k]) if (pop_pc_log[k] == pc) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s cyc=%0d timeout waiting for pop got=none expected=%h", name, cyc, pc);
    end
  endtask

  task automatic wait_head(string name, logic [31:0] pc, int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (inst_valid && inst_pc == pc) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s cyc=%0d timeout waiting for head got=%h expected=%h", name, cyc, inst_pc, pc);
    end
  endtask

  initial begin
    int idx, nxp;
    errors = 0; checks = 0; cyc = 0; model_ok = 1'b0;
    drv_reset = 1'b0; drv_irq = 1'b0; drv_illop = 1'b0; drv_redir = 1'b0;
    drv_ready = 1'b1; drv_rpc = '0; salt = '0; lat_lo = 1; lat_hi = 1;
    RESET = 1'b0; IRQ = 1'b0; illop = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; imem_ack = 1'b0; imem_data = '0;

    // Reset state and in-order delivery with 1-cycle memory returning word = addr
    run(2);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_xp_valid", 32'(xp_valid), 32'h0);
    chk("rst_xp_pc", xp_pc, 32'h0);
    do_reset();
    run(10);
    chk_at("t1_first_req", req_log, 0, 32'h80000000);
    chk_at("t1_pop0", pop_pc_log, 0, 32'h80000000);
    chk_at("t1_pop1", pop_pc_log, 1, 32'h80000004);
    chk_at("t1_pop2", pop_pc_log, 2, 32'h80000008);
    chk_at("t1_data0", pop_data_log, 0, 32'h80000000);

    // Fill to DEPTH with decode stalled, then drain
    lat_lo = 3; lat_hi = 3; drv_ready = 1'b0;
    do_reset();
    run(30);
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_full_valid", 32'(inst_valid), 32'h1);
    chk("t2_full_noreq", 32'(imem_req), 32'h0);
    drv_ready = 1'b1;
    run(20);
    for (int i = 0; i < 4; i++) chk_at("t2_drain", pop_pc_log, i, 32'h80000000 + 32'(4 * i));
    chk_at("t2_resume", req_log, 4, 32'h80000010);

    // Redirect while a request is outstanding
    do_reset();
    step();
    pulse_redir(32'h80001002);
    run(12);
    chk_at("t3_req0", req_log, 0, 32'h80000000);
    chk_at("t3_req1", req_log, 1, 32'h80001000);
    chk_at("t3_pop0", pop_pc_log, 0, 32'h80001000);

    // User code cannot redirect into supervisor space
    pulse_redir(32'h00000100);
    clear_logs();
    wait_pop("t4_user_pop", 32'h00000100, 40);
    idx = req_log.size();
    pulse_redir(32'h80002000);
    run(10);
    chk_at("t4_user_redir", req_log, idx, 32'h00002000);

    // IRQ taken on a user-mode head
    drv_ready = 1'b0;
    pulse_redir(32'h00000040);
    wait_head("t5_head_user", 32'h00000040, 40);
    drv_irq = 1'b1;
    step();
    drv_irq = 1'b0;
    chk("t5_xp_valid", 32'(xp_valid), 32'h1);
    chk("t5_xp_pc", xp_pc, 32'h00000044);
    idx = req_log.size();
    run(4);
    chk_at("t5_vector", req_log, idx, 32'h80000008);

    // IRQ ignored on a supervisor-mode head
    do_reset();
    pulse_redir(32'h80000040);
    wait_head("t5_head_sup", 32'h80000040, 40);
    nxp = xp_log.size();
    drv_irq = 1'b1;
    run(5);
    drv_irq = 1'b0;
    chk("t5_no_irq", 32'(xp_log.size()), 32'(nxp));
    chk("t5_head_kept", inst_pc, 32'h80000040);

    // illop wins over a simultaneous redirect
    drv_ready = 1'b1; lat_lo = 2; lat_hi = 2;
    do_reset();
    idx = req_log.size();
    drv_illop = 1'b1; drv_redir = 1'b1; drv_rpc = 32'h80005000;
    step();
    drv_illop = 1'b0; drv_redir = 1'b0;
    run(4);
    chk_at("t6_illop_prio", req_log, idx, 32'h80000004);

    // Reset abandons an outstanding request
    lat_lo = 4; lat_hi = 4; salt = 32'h00ff00ff;
    pulse_redir(32'h80000100);
    step();
    drv_reset = 1'b0;
    step();
    drv_reset = 1'b1;
    clear_logs();
    run(14);
    chk_at("t7_restart", req_log, 0, 32'h80000000);
    chk_at("t7_first_pop", pop_pc_log, 0, 32'h80000000);
    chk_at("t7_first_data", pop_data_log, 0, 32'h80000000 ^ 32'h00ff00ff);

    // Randomized traffic against the model
    lat_lo = 1;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) begin
        lat_hi = int'($urandom_range(6, 1));
        salt   = $urandom;
      end
      drv_reset = ($urandom_range(199, 0) != 0);
      drv_illop = ($urandom_range(39, 0) == 0);
      drv_redir = ($urandom_range(14, 0) == 0);
      drv_rpc   = $urandom;
      drv_irq   = ($urandom_range(9, 0) == 0);
      drv_ready = ($urandom_range(3, 0) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
